// File: rtl/hazard_scoreboard_controller_if.sv
// Pipeline <-> hazard/freeze controller bundle.
// master: pipeline side (ID fields, forwarding enable, SRAM ready).
// slave:  controller side (hazard, freeze, timeout, stall counter).
interface hazard_scoreboard_controller_if #(
  parameter int COUNT_W = 16
);
  logic [4:0]         ID_src1;
  logic [4:0]         ID_src2;
  logic               ID_uses_src2;
  logic [4:0]         ID_dest;
  logic               ID_WB_en;
  logic               ID_MEM_R_en;
  logic               ID_MEM_W_en;
  logic               forwarding_en;
  logic               mem_ready;
  logic               hazard_detected;
  logic               freeze;
  logic               mem_timeout;
  logic [COUNT_W-1:0] stall_count;

  modport master (
    output ID_src1, ID_src2, ID_uses_src2, ID_dest, ID_WB_en, ID_MEM_R_en,
           ID_MEM_W_en, forwarding_en, mem_ready,
    input  hazard_detected, freeze, mem_timeout, stall_count
  );

  modport slave (
    input  ID_src1, ID_src2, ID_uses_src2, ID_dest, ID_WB_en, ID_MEM_R_en,
           ID_MEM_W_en, forwarding_en, mem_ready,
    output hazard_detected, freeze, mem_timeout, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard_controller.sv
// Stall/freeze controller for the 5-stage pipeline. Shadows the EXE and MEM
// instructions in a 2-entry scoreboard, raises hazard_detected for RAW /
// load-use, freezes the whole pipe while the SRAM is busy, and latches a
// terminal timeout error if an access never completes.
module hazard_scoreboard_controller #(
  parameter int MAX_WAIT = 64,
  parameter int COUNT_W  = 16
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_controller_if.slave bus
);
  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
  } slot_t;

  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

  slot_t              exe_slot, mem_slot;
  state_t             state, state_nxt;
  logic [WCNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic               timeout_q;
  logic [COUNT_W-1:0] stall_q;
  logic               exe_hit, mem_hit, hazard, mem_busy, frz;

  // R0 is hardwired zero, so it never creates a dependency.
  function automatic logic src_match(input logic [4:0] s, input slot_t x);
    return x.valid & x.wb_en & (x.dest != 5'd0) & (s == x.dest);
  endfunction

  // Dependency check against the shadowed EXE/MEM instructions.
  always_comb begin
    exe_hit  = src_match(bus.ID_src1, exe_slot) |
               (bus.ID_uses_src2 & src_match(bus.ID_src2, exe_slot));
    mem_hit  = src_match(bus.ID_src1, mem_slot) |
               (bus.ID_uses_src2 & src_match(bus.ID_src2, mem_slot));
    // With forwarding only a load still in EXE cannot be bypassed in time.
    hazard   = bus.forwarding_en ? (exe_hit & exe_slot.mem_r_en)
                                 : (exe_hit | mem_hit);
    mem_busy = mem_slot.valid & (mem_slot.mem_r_en | mem_slot.mem_w_en) &
               ~bus.mem_ready;
    frz      = mem_busy | (state == ERR);
  end

  assign bus.hazard_detected = hazard;
  assign bus.freeze          = frz;
  assign bus.mem_timeout     = timeout_q;
  assign bus.stall_count     = stall_q;

  // Scoreboard shift; freeze wins over hazard so nothing moves while frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_slot <= '0;
      mem_slot <= '0;
    end else if (!frz) begin
      mem_slot <= exe_slot;
      if (hazard) exe_slot <= '0;
      else        exe_slot <= '{valid: 1'b1, dest: bus.ID_dest,
                                wb_en: bus.ID_WB_en, mem_r_en: bus.ID_MEM_R_en,
                                mem_w_en: bus.ID_MEM_W_en};
    end
  end

  // Watchdog state register; the timeout flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      timeout_q <= timeout_q | (state_nxt == ERR);
    end
  end

  // Watchdog next state: the first busy cycle counts as wait 1, so an access
  // with exactly MAX_WAIT low-ready cycles completes and one more times out.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      RUN: if (mem_busy) begin
        state_nxt    = WAIT;
        wait_cnt_nxt = WCNT_W'(1);
      end
      WAIT: begin
        if (bus.mem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WCNT_W'(MAX_WAIT)) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  // Saturating stall counter; freeze and hazard in one cycle count once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             stall_q <= '0;
    else if ((frz | hazard) && stall_q != '1) stall_q <= stall_q + 1'b1;
  end
endmodule

// File: tb/tb_hazard_scoreboard_controller.sv
// Bench for hazard_scoreboard_controller: each driven cycle pushes its
// expected hazard/freeze/timeout/stall_count; a negedge monitor pops and
// compares. Narrow COUNT_W so the counter reaches saturation in the run.
module tb_hazard_scoreboard_controller;
  localparam int COUNT_W  = 5;
  localparam int MAX_WAIT = 8;

  typedef struct {
    string              tag;
    logic               hz;
    logic               fz;
    logic               to;
    logic [COUNT_W-1:0] sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_controller_if #(.COUNT_W(COUNT_W)) bus ();

  hazard_scoreboard_controller #(.MAX_WAIT(MAX_WAIT), .COUNT_W(COUNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t               q[$];
  exp_t               mon_e;
  int                 n_cmp = 0;
  int                 n_err = 0;
  logic [COUNT_W-1:0] sc_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one ID cycle just after the edge and queue its expectations.
  task automatic issue(input string tag, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u2, input logic [4:0] d, input logic wb,
                       input logic mr, input logic mw, input logic fwd,
                       input logic rdy, input logic ehz, input logic efz,
                       input logic eto);
    exp_t e;
    @(posedge clk);
    #1;
    bus.ID_src1       = s1;
    bus.ID_src2       = s2;
    bus.ID_uses_src2  = u2;
    bus.ID_dest       = d;
    bus.ID_WB_en      = wb;
    bus.ID_MEM_R_en   = mr;
    bus.ID_MEM_W_en   = mw;
    bus.forwarding_en = fwd;
    bus.mem_ready     = rdy;
    e.tag = tag; e.hz = ehz; e.fz = efz; e.to = eto; e.sc = sc_model;
    q.push_back(e);
    if ((ehz | efz) && sc_model != '1) sc_model = sc_model + 1'b1;
  endtask

  task automatic nop(input string tag, input logic fwd, input logic rdy,
                     input logic efz, input logic eto);
    issue(tag, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, fwd, rdy, 1'b0, efz, eto);
  endtask

  // Output monitor, half a cycle away from the driving edge.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk({mon_e.tag, ":hazard"}, 32'(bus.hazard_detected), 32'(mon_e.hz));
      chk({mon_e.tag, ":freeze"}, 32'(bus.freeze), 32'(mon_e.fz));
      chk({mon_e.tag, ":timeout"}, 32'(bus.mem_timeout), 32'(mon_e.to));
      chk({mon_e.tag, ":stall_cnt"}, 32'(bus.stall_count), 32'(mon_e.sc));
    end
  end

  task automatic drain();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ":hazard"}, 32'(bus.hazard_detected), 32'd0);
    chk({tag, ":freeze"}, 32'(bus.freeze), 32'd0);
    chk({tag, ":timeout"}, 32'(bus.mem_timeout), 32'd0);
    chk({tag, ":stall_cnt"}, 32'(bus.stall_count), 32'd0);
  endtask

  initial begin
    rst               = 1'b1;
    bus.ID_src1       = '0;
    bus.ID_src2       = '0;
    bus.ID_uses_src2  = 1'b0;
    bus.ID_dest       = '0;
    bus.ID_WB_en      = 1'b0;
    bus.ID_MEM_R_en   = 1'b0;
    bus.ID_MEM_W_en   = 1'b0;
    bus.forwarding_en = 1'b0;
    bus.mem_ready     = 1'b1;
    sc_model          = '0;
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    // RAW without forwarding: stall while producer sits in EXE then MEM.
    issue("raw_p",  5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("raw_c1", 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    issue("raw_c2", 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    issue("raw_c3", 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) nop("raw_n", 1'b0, 1'b1, 1'b0, 1'b0);

    // Load-use with forwarding: one bubble only.
    issue("lu_ld", 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("lu_c1", 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    issue("lu_c2", 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) nop("lu_n", 1'b1, 1'b1, 1'b0, 1'b0);
    // ALU producer with forwarding: no stall.
    issue("alu_p", 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("alu_c", 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) nop("alu_n", 1'b1, 1'b1, 1'b0, 1'b0);

    // R0 producer never stalls; src2 only counts when used.
    issue("r0_p",  5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("r0_c",  5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) nop("r0_n", 1'b0, 1'b1, 1'b0, 1'b0);
    issue("u2_p",  5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("u2_off",5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("u2_on", 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    issue("u2_on2",5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) nop("u2_n", 1'b0, 1'b1, 1'b0, 1'b0);

    // SRAM wait of 4 cycles.
    issue("sw_ld", 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    nop("sw_n0", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) nop("sw_wt", 1'b0, 1'b0, 1'b1, 1'b0);
    nop("sw_go", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) nop("sw_n", 1'b0, 1'b1, 1'b0, 1'b0);

    // Load-use hazard held under a 3-cycle store freeze; bubble afterwards.
    issue("fh_st",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("fh_ld",  5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3)
      issue("fh_frz", 5'd6, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    issue("fh_bub", 5'd6, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    issue("fh_go",  5'd6, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) nop("fh_n", 1'b1, 1'b1, 1'b0, 1'b0);

    // Exactly MAX_WAIT low cycles: completes without error.
    issue("mw_ld", 5'd0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    nop("mw_n0", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (MAX_WAIT) nop("mw_wt", 1'b0, 1'b0, 1'b1, 1'b0);
    nop("mw_go", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) nop("mw_n", 1'b0, 1'b1, 1'b0, 1'b0);

    // MAX_WAIT+1 low cycles: timeout, freeze stuck even with ready; counter saturates.
    issue("to_ld", 5'd0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    nop("to_n0", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (MAX_WAIT + 1) nop("to_wt", 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) nop("to_err", 1'b0, 1'b1, 1'b1, 1'b1);
    drain();

    // Reset from the error state clears everything asynchronously.
    rst = 1'b1;
    #2;
    chk_reset("rst_err");
    sc_model = '0;
    @(negedge clk);
    rst = 1'b0;
    nop("post_rst", 1'b0, 1'b1, 1'b0, 1'b0);
    nop("post_rst", 1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard_controller.md
Name: hazard_scoreboard_controller

Overview:
- Central stall/freeze controller for the 5-stage pipeline.
- Shadows the destination, WB_en, MEM_R_en and MEM_W_en of the instructions in EXE and MEM in a 2-entry scoreboard.
- Drives the ID-stage hazard_detected input (bubble insertion) and a global freeze for multi-cycle SRAM accesses, including a memory timeout watchdog.
- Also keeps a saturating stall counter for performance measurement.

Parameters:
- MAX_WAIT, 64, freeze cycles allowed for one memory access before timeout error.
- COUNT_W, 16, width of stall_count.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous reset, active high.
- ID_src1  input  5  first source register of the instruction in ID.
- ID_src2  input  5  second source register of the instruction in ID.
- ID_uses_src2  input  1  1 when ID_src2 is actually read (register-form ALU op, store or BNE).
- ID_dest  input  5  destination register of the instruction in ID.
- ID_WB_en  input  1  ID instruction writes back.
- ID_MEM_R_en  input  1  ID instruction is a load.
- ID_MEM_W_en  input  1  ID instruction is a store.
- forwarding_en  input  1  forwarding unit enabled.
- mem_ready  input  1  SRAM has completed the current access.
- hazard_detected  output  1  combinational; zeroes ID control signals this cycle.
- freeze  output  1  combinational; holds PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
- mem_timeout  output  1  sticky, registered error flag.
- stall_count  output  COUNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (async, rst=1):
  - EXE_slot and MEM_slot invalid (all fields 0).
  - state=RUN, wait_cnt=0, stall_count=0, mem_timeout=0.
  - hazard_detected and freeze evaluate to 0 because both slots are invalid.
- Slot fields: {valid, dest[4:0], WB_en, MEM_R_en, MEM_W_en}.
- Match rule: match(s,X) = X.valid & X.WB_en & (X.dest != 0) & (s == X.dest).
  - Register 0 never causes a hazard.
  - src2 is compared only when ID_uses_src2=1.
- Hazard rule:
  - forwarding_en=0: hazard_detected = any src matching EXE_slot or MEM_slot.
  - forwarding_en=1: hazard_detected = any src matching EXE_slot, and only when EXE_slot.MEM_R_en=1 (load-use).
  - Evaluated combinationally in the same cycle as the ID inputs.
- Memory busy: mem_busy = MEM_slot.valid & (MEM_slot.MEM_R_en | MEM_slot.MEM_W_en) & ~mem_ready.
- Freeze: freeze = mem_busy | (state==ERR).
- Slot update on each rising edge when freeze=0:
  - MEM_slot <= EXE_slot.
  - If hazard_detected=1, EXE_slot <= bubble (valid=0); otherwise EXE_slot <= {1, ID fields}.
- When freeze=1: both slots hold.
  - freeze has priority over hazard: no bubble is inserted and no shift occurs.
  - hazard_detected is still driven from the held slots.
- FSM (wait_cnt is MAX_WAIT-wide-safe, at least clog2(MAX_WAIT+1) bits):
  - RUN: if mem_busy, go to WAIT with wait_cnt=1.
  - WAIT:
    - mem_ready=1: go to RUN, wait_cnt=0.
    - else if wait_cnt==MAX_WAIT: go to ERR, mem_timeout<=1.
    - else wait_cnt+1.
  - ERR: terminal until rst. freeze=1 and mem_timeout=1 regardless of mem_ready.
- Consequence: an access that has mem_ready=0 for exactly MAX_WAIT cycles completes; one with MAX_WAIT+1 low cycles times out.
- stall_count increments by 1 in every cycle where (freeze | hazard_detected)=1.
  - Simultaneous freeze and hazard counts once.
  - Saturates at 2^COUNT_W-1, never wraps.
  - Cycles spent in ERR also count, up to saturation.
- Reset mid-stall: async clear of everything above. The frozen instruction is lost; the pipeline registers are reset by the same rst.
- Latency:
  - hazard_detected and freeze take 0 cycles from their inputs.
  - Slot contents reflect the ID instruction 1 cycle later (EXE) and 2 cycles later (MEM).

Test Plan:
- RAW without forwarding: ID_dest=3, ID_WB_en=1, forwarding_en=0; next instruction has ID_src1=3 -> hazard_detected=1 for 2 consecutive cycles (matches in EXE, then MEM), then 0; stall_count=2.
- Load-use with forwarding: load with dest=5, then ID_src2=5, ID_uses_src2=1, forwarding_en=1 -> hazard_detected=1 for exactly 1 cycle. Same sequence with a non-load ALU producer -> hazard_detected stays 0.
- R0 and unused src2: producer dest=0 with src1=0 -> no hazard. Producer dest=7 with ID_src2=7 and ID_uses_src2=0 -> no hazard.
- SRAM wait: load reaches MEM with mem_ready=0 for 4 cycles -> freeze=1 for 4 cycles, slots unchanged, state RUN->WAIT->RUN, stall_count +4, mem_timeout=0.
- Timeout: MAX_WAIT=8, mem_ready held 0 -> mem_timeout=1 after the 9th low cycle, freeze stuck at 1 even after mem_ready=1; assert rst -> all outputs 0.
- Freeze and hazard together: load-use hazard in EXE while the MEM store waits 3 cycles -> EXE_slot is held (no bubble), hazard_detected=1 throughout, stall_count +3 (not +6). The bubble is inserted on the first unfrozen cycle.
